seg7_scan_display: RTL and testbench

//  AXI-Stream sink for the accumulator's two-digit 7-segment frames ({tens,ones}).

---
 rtl/seg7_scan_display_if.sv | 34 +++
 rtl/seg7_scan_display.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_display.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_display_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_display_if
//   Stream link carrying one two-digit 7-segment frame per transfer.
//   A transfer happens on a rising clock edge where s_valid and s_ready are
//   both high.
//
//   Signals
//     s_valid  producer -> consumer  frame on s_data is valid
//     s_ready  consumer -> producer  consumer can take a frame this cycle
//     s_data   producer -> consumer  [0]=ones, [1]=tens; bit0 = seg a, 1 = lit
//
//   Modports
//     master   frame producer (upstream accumulator, or a testbench)
//     slave    frame consumer (seg7_scan_display)
// -----------------------------------------------------------------------------
interface seg7_scan_display_if;

  logic            s_valid;
  logic            s_ready;
  logic [1:0][6:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface : seg7_scan_display_if

// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
//   Stream sink for two-digit 7-segment frames ({tens, ones}). Each accepted
//   frame is latched and time-multiplexed onto a shared cathode bus driving
//   two common-anode positions (all drives active low).
//
//   A frame is kept on the display for at least HOLD_FRAMES complete scans
//   (ones slot + tens slot) before the next one is accepted; until then
//   s_ready stays low and upstream is back-pressured. After the hold has been
//   satisfied the current frame keeps scanning indefinitely until a new one
//   arrives.
//
//   Parameters
//     REFRESH_DIV  clk cycles each digit is lit per scan slot (>= 2)
//     HOLD_FRAMES  full scans a frame is shown before s_ready re-asserts (>= 1)
//
//   Ports
//     clk      in   rising-edge clock
//     rstn     in   asynchronous active-low reset
//     s_axis   slave modport of seg7_scan_display_if (s_valid/s_ready/s_data)
//     seg_n    out  [6:0] cathode drive, 0 = segment on, bit0 = seg a
//     an_n     out  [1:0] anode select, 0 = digit on; [0]=ones, [1]=tens
//     disp_on  out  1 while a frame is being displayed
//
//   Timing
//     Accept at edge k -> edge k+1 drives the ones digit of the new frame.
//     Each digit is lit for REFRESH_DIV cycles; one scan is 2*REFRESH_DIV.
//     s_ready rises HOLD_FRAMES*2*REFRESH_DIV cycles after the accept edge,
//     so with s_valid held high the next accept lands on the following edge.
// -----------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int REFRESH_DIV = 4,
  parameter int HOLD_FRAMES = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  seg7_scan_display_if.slave         s_axis,
  output logic [6:0]                 seg_n,
  output logic [1:0]                 an_n,
  output logic                       disp_on
);

  // ---------------------------------------------------------------------------
  // Local sizing
  // ---------------------------------------------------------------------------
  localparam int DIV_W  = $clog2(REFRESH_DIV);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  // Blank drive pattern: every cathode and every anode released.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_BLANK  = 2'b11;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic {
    EMPTY = 1'b0,   // nothing latched, display blanked
    SHOW  = 1'b1    // a frame is latched and being scanned
  } state_t;

  state_t            state_q,    state_d;
  logic [1:0][6:0]   frame_q,    frame_d;
  logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
  logic              dig_sel_q,  dig_sel_d;   // 0 = ones slot, 1 = tens slot
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [6:0]        seg_n_d;
  logic [1:0]        an_n_d;
  logic              disp_on_d;

  logic              ready;
  logic              accept;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Ready is a pure function of registered state so there is no combinational
  // path from s_valid back to s_ready.
  assign ready         = (state_q == EMPTY) || (hold_cnt_q == HOLD_MAX);
  assign s_axis.s_ready = ready;
  assign accept        = s_axis.s_valid && ready;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default at the top of the block, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    div_cnt_d  = div_cnt_q;
    dig_sel_d  = dig_sel_q;
    hold_cnt_d = hold_cnt_q;

    if (accept) begin
      // A new frame always restarts the scan at the ones digit, even when the
      // same edge would otherwise have wrapped a slot or a full scan.
      state_d    = SHOW;
      frame_d    = s_axis.s_data;
      div_cnt_d  = '0;
      dig_sel_d  = 1'b0;
      hold_cnt_d = '0;
    end else if (state_q == SHOW) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        dig_sel_d = ~dig_sel_q;
        // Leaving the tens slot completes one full scan of the frame.
        if (dig_sel_q && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end

    // Display drive follows the scan registers one cycle later.
    seg_n_d   = SEG_BLANK;
    an_n_d    = AN_BLANK;
    disp_on_d = 1'b0;
    if (state_q == SHOW) begin
      seg_n_d   = ~frame_q[dig_sel_q];
      an_n_d    = ~(2'b01 << dig_sel_q);
      disp_on_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  // NOTE: the frame register is reset along with the control state; it is
  // only two digits wide and a defined value keeps a restart deterministic.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= EMPTY;
      frame_q    <= '0;
      div_cnt_q  <= '0;
      dig_sel_q  <= 1'b0;
      hold_cnt_q <= '0;
      seg_n      <= SEG_BLANK;
      an_n       <= AN_BLANK;
      disp_on    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      div_cnt_q  <= div_cnt_d;
      dig_sel_q  <= dig_sel_d;
      hold_cnt_q <= hold_cnt_d;
      seg_n      <= seg_n_d;
      an_n       <= an_n_d;
      disp_on    <= disp_on_d;
    end
  end

endmodule : seg7_scan_display

// File: tb/tb_seg7_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_display
//   Directed bench for seg7_scan_display. Two instances share clk/rstn:
//     dut_a  REFRESH_DIV=4, HOLD_FRAMES=2
//     dut_b  REFRESH_DIV=2, HOLD_FRAMES=1
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_display;

  logic clk;
  logic rstn;

  seg7_scan_display_if a_if ();
  seg7_scan_display_if b_if ();

  logic [6:0] a_seg_n, b_seg_n;
  logic [1:0] a_an_n,  b_an_n;
  logic       a_disp_on, b_disp_on;

  int checks = 0;
  int errors = 0;

  seg7_scan_display #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut_a (
    .clk     (clk),
    .rstn    (rstn),
    .s_axis  (a_if),
    .seg_n   (a_seg_n),
    .an_n    (a_an_n),
    .disp_on (a_disp_on)
  );

  seg7_scan_display #(.REFRESH_DIV(2), .HOLD_FRAMES(1)) dut_b (
    .clk     (clk),
    .rstn    (rstn),
    .s_axis  (b_if),
    .seg_n   (b_seg_n),
    .an_n    (b_an_n),
    .disp_on (b_disp_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frames: [1]=tens, [0]=ones, 1 = lit.
  logic [1:0][6:0] fa, fb, fc;
  logic [1:0][6:0] frames_b [3];

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_tens;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    int         m;
    int         k;

    fa = {7'b1011011, 7'b1101101};  // "25"
    fb = {7'b1001111, 7'b0000110};  // "31"
    fc = {7'b1111111, 7'b0000111};  // "87"
    frames_b[0] = fa;
    frames_b[1] = fb;
    frames_b[2] = fc;

    rstn        = 1'b0;
    a_if.s_valid = 1'b0;
    a_if.s_data  = '0;
    b_if.s_valid = 1'b0;
    b_if.s_data  = '0;

    // ---- Reset state ------------------------------------------------------
    #7;
    check("rst_seg_n",   a_seg_n, 7'h7F);
    check("rst_an_n",    {5'b0, a_an_n}, 7'h03);
    check("rst_disp_on", {6'b0, a_disp_on}, 7'h00);
    check("rst_b_an_n",  {5'b0, b_an_n}, 7'h03);
    #6;
    rstn = 1'b1;
    #1;
    check("rst_ready", {6'b0, a_if.s_ready}, 7'h01);

    // ---- Single frame "25", scan pattern and hold -------------------------
    a_if.s_valid = 1'b1;
    a_if.s_data  = fa;
    tick();  // accept edge
    a_if.s_valid = 1'b0;
    a_if.s_data  = '0;
    check("acc_ready_low", {6'b0, a_if.s_ready}, 7'h00);
    check("acc_edge_blank", {5'b0, a_an_n}, 7'h03);

    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_tens = (((i - 1) / 4) % 2) == 1;
      exp_an   = exp_tens ? 2'b01 : 2'b10;
      exp_seg  = exp_tens ? 7'b0100100 : 7'b0010010;
      check($sformatf("scan_an_%0d", i),  {5'b0, a_an_n}, {5'b0, exp_an});
      check($sformatf("scan_seg_%0d", i), a_seg_n, exp_seg);
      check($sformatf("hold_ready_%0d", i), {6'b0, a_if.s_ready}, {6'b0, i == 16});
      if (i == 1) check("scan_disp_on", {6'b0, a_disp_on}, 7'h01);
    end

    // ---- Back-pressure: "31" accepted now, "87" held valid during hold -----
    a_if.s_valid = 1'b1;
    a_if.s_data  = fb;
    tick();  // accept of fb
    check("bp_ready_low", {6'b0, a_if.s_ready}, 7'h00);
    a_if.s_data = fc;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_tens = (((i - 1) / 4) % 2) == 1;
      exp_an   = exp_tens ? 2'b01 : 2'b10;
      exp_seg  = exp_tens ? ~fb[1] : ~fb[0];
      check($sformatf("bp_an_%0d", i),  {5'b0, a_an_n}, {5'b0, exp_an});
      check($sformatf("bp_seg_%0d", i), a_seg_n, exp_seg);
      check($sformatf("bp_ready_%0d", i), {6'b0, a_if.s_ready}, {6'b0, i == 16});
    end
    // The edge at i=17 accepted fc; its ones digit shows one edge later.
    a_if.s_valid = 1'b0;
    a_if.s_data  = '0;
    tick();
    check("new_an",    {5'b0, a_an_n}, 7'h02);
    check("new_seg",   a_seg_n, ~fc[0]);
    check("new_ready", {6'b0, a_if.s_ready}, 7'h00);
    for (int i = 0; i < 3; i++) tick();
    check("new_seg_ones_end", a_seg_n, ~fc[0]);
    tick();
    check("new_an_tens",  {5'b0, a_an_n}, 7'h01);
    check("new_seg_tens", a_seg_n, ~fc[1]);

    // ---- Reset mid-scan during the tens slot ------------------------------
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_seg",  a_seg_n, 7'h7F);
    check("mid_rst_an",   {5'b0, a_an_n}, 7'h03);
    check("mid_rst_disp", {6'b0, a_disp_on}, 7'h00);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("mid_rst_ready", {6'b0, a_if.s_ready}, 7'h01);
    a_if.s_valid = 1'b1;
    a_if.s_data  = fa;
    tick();
    a_if.s_valid = 1'b0;
    a_if.s_data  = '0;
    check("restart_blank", {5'b0, a_an_n}, 7'h03);
    tick();
    check("restart_an",   {5'b0, a_an_n}, 7'h02);
    check("restart_seg",  a_seg_n, ~fa[0]);
    check("restart_disp", {6'b0, a_disp_on}, 7'h01);

    // ---- REFRESH_DIV=2, HOLD_FRAMES=1, s_valid held high ------------------
    // Accepts land on edges 0, 5, 10 relative to the first accept.
    check("b_ready_idle", {6'b0, b_if.s_ready}, 7'h01);
    b_if.s_valid = 1'b1;
    b_if.s_data  = frames_b[0];
    tick();
    b_if.s_data = frames_b[1];
    for (int j = 1; j <= 11; j++) begin
      tick();
      m = j % 5;
      k = (j - 1) / 5;
      exp_tens = (m == 3) || (m == 4);
      exp_an   = exp_tens ? 2'b01 : 2'b10;
      exp_seg  = exp_tens ? ~frames_b[k][1] : ~frames_b[k][0];
      check($sformatf("b_an_%0d", j),    {5'b0, b_an_n}, {5'b0, exp_an});
      check($sformatf("b_seg_%0d", j),   b_seg_n, exp_seg);
      check($sformatf("b_ready_%0d", j), {6'b0, b_if.s_ready}, {6'b0, m == 4});
      if (j == 5) b_if.s_data = frames_b[2];
      if (j == 10) begin
        b_if.s_valid = 1'b0;
        b_if.s_data  = '0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seg7_scan_display
